// File: rtl/load_store_unit_if.sv
// Pipeline request/response and data-memory signals of the load/store unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault,
           mem_addr, mem_wdata, mem_we, mem_re
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault,
           mem_addr, mem_wdata, mem_we, mem_re
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: byte/half/word loads with extension, SB/SH via read-modify-write.
// Optional LSU_MISALIGN_TRAP_EN: fault misaligned H/HU/SH/W/SW instead of forcing alignment.
module load_store_unit #(
  parameter int MEM_WORDS = 1024
) (
  input logic clk,
  input logic rst,
  load_store_unit_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LD_REQ, LD_WAIT, ST_RD, ST_WAIT, ST_WR, RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t      state;
  req_t        cap;
  logic [31:0] merge_q;
  logic [31:0] ld_q;
  logic        fault_q;

  logic        ld_legal, st_legal, misalign, req_fault;
  logic [1:0]  off;
  logic [4:0]  shamt;
  logic [31:0] sh_rd, ld_val, lane_mask, st_val;

  always_comb begin
    ld_legal = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
               (bus.req_funct3 == 3'b010) || (bus.req_funct3 == 3'b100) ||
               (bus.req_funct3 == 3'b101);
    st_legal = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
               (bus.req_funct3 == 3'b010);
`ifdef LSU_MISALIGN_TRAP_EN
    misalign = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
               ((bus.req_funct3 == 3'b010) && (bus.req_addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    req_fault = (bus.req_we ? !st_legal : !ld_legal) || misalign;
  end

  // Lane offset with alignment forced; in trap mode misaligned requests never get here.
  always_comb begin
    case (cap.funct3[1:0])
      2'b01:   off = {cap.addr[1], 1'b0};
      2'b10:   off = 2'b00;
      default: off = cap.addr[1:0];
    endcase
    shamt     = {off, 3'b000};
    sh_rd     = bus.mem_rdata >> shamt;
    lane_mask = (cap.funct3[1:0] == 2'b01) ? 32'h0000_FFFF : 32'h0000_00FF;
    st_val    = (bus.mem_rdata & ~(lane_mask << shamt)) |
                ((cap.wdata & lane_mask) << shamt);
    case (cap.funct3)
      3'b000:  ld_val = {{24{sh_rd[7]}}, sh_rd[7:0]};
      3'b100:  ld_val = {24'h0, sh_rd[7:0]};
      3'b001:  ld_val = {{16{sh_rd[15]}}, sh_rd[15:0]};
      3'b101:  ld_val = {16'h0, sh_rd[15:0]};
      default: ld_val = sh_rd;
    endcase
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.mem_wdata = (state != ST_WR)       ? 32'h0 :
                         (cap.funct3 == 3'b010) ? cap.wdata : merge_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cap           <= '0;
      merge_q       <= '0;
      ld_q          <= '0;
      fault_q       <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_fault <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_re    <= 1'b0;
    end else begin
      bus.rsp_valid <= 1'b0;
      bus.mem_re    <= 1'b0;
      bus.mem_we    <= 1'b0;
      case (state)
        IDLE: if (bus.req_valid) begin
          cap          <= '{we: bus.req_we, funct3: bus.req_funct3,
                            addr: bus.req_addr, wdata: bus.req_wdata};
          bus.mem_addr <= {bus.req_addr[31:2], 2'b00};
          ld_q         <= '0;
          fault_q      <= req_fault;
          if (req_fault) begin
            state <= RESP;
          end else if (!bus.req_we) begin
            state      <= LD_REQ;
            bus.mem_re <= 1'b1;
          end else if (bus.req_funct3 == 3'b010) begin
            state      <= ST_WR;
            bus.mem_we <= 1'b1;
          end else begin
            state      <= ST_RD;
            bus.mem_re <= 1'b1;
          end
        end
        LD_REQ:  state <= LD_WAIT;
        LD_WAIT: begin
          ld_q  <= ld_val;
          state <= RESP;
        end
        ST_RD:   state <= ST_WAIT;
        ST_WAIT: begin
          merge_q    <= st_val;
          bus.mem_we <= 1'b1;
          state      <= ST_WR;
        end
        ST_WR:   state <= RESP;
        RESP: begin
          bus.rsp_valid <= 1'b1;
          bus.rsp_rdata <= ld_q;
          bus.rsp_fault <= fault_q;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  wire unused_ok = |{MEM_WORDS, cap.we};
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a one-cycle-latency word memory model.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  load_store_unit_if bus();

  load_store_unit #(.MEM_WORDS(1024)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  logic [31:0] mem [0:255];
  int n_re = 0, n_we = 0, n_rv = 0;
  int total = 0, passed = 0;

  always @(posedge clk) begin
    if (bus.mem_re) begin
      bus.mem_rdata <= mem[bus.mem_addr[9:2]];
      n_re <= n_re + 1;
    end
    if (bus.mem_we) begin
      mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
      n_we <= n_we + 1;
    end
    if (bus.rsp_valid) n_rv <= n_rv + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, output int lat, output int dre, output int dwe);
    int re0, we0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = a; bus.req_wdata = d;
    re0 = n_re; we0 = n_we;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 0;
    while (!bus.rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    dre = n_re - re0;
    dwe = n_we - we0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int lat, dre, dwe, v0, w0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = '0; bus.req_wdata = '0;
    #1;
    chk("rst_ready",    {31'h0, bus.req_ready}, 32'h1);
    chk("rst_rsp_valid",{31'h0, bus.rsp_valid}, 32'h0);
    chk("rst_rdata",    bus.rsp_rdata, 32'h0);
    chk("rst_fault",    {31'h0, bus.rsp_fault}, 32'h0);
    chk("rst_mem_we_re",{30'h0, bus.mem_we, bus.mem_re}, 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Preload through the unit with SW.
    do_req(1'b1, 3'b010, 32'h100, 32'h8899AABB, lat, dre, dwe);
    chk("sw100_lat", lat, 2);
    chk("sw100_we_cnt", dwe, 1);
    chk("sw100_re_cnt", dre, 0);
    chk("sw100_mem", mem[8'h40], 32'h8899AABB);
    do_req(1'b1, 3'b010, 32'h200, 32'h11223344, lat, dre, dwe);
    chk("sw200_lat", lat, 2);
    chk("sw200_rdata", bus.rsp_rdata, 32'h0);

    do_req(1'b0, 3'b000, 32'h101, 32'h0, lat, dre, dwe);
    chk("lb101_lat", lat, 3);
    chk("lb101_rdata", bus.rsp_rdata, 32'hFFFFFFAA);
    chk("lb101_fault", {31'h0, bus.rsp_fault}, 32'h0);
    chk("lb101_re_cnt", dre, 1);
    do_req(1'b0, 3'b100, 32'h103, 32'h0, lat, dre, dwe);
    chk("lbu103_rdata", bus.rsp_rdata, 32'h00000088);
    do_req(1'b0, 3'b101, 32'h102, 32'h0, lat, dre, dwe);
    chk("lhu102_rdata", bus.rsp_rdata, 32'h00008899);
    do_req(1'b0, 3'b001, 32'h102, 32'h0, lat, dre, dwe);
    chk("lh102_rdata", bus.rsp_rdata, 32'hFFFF8899);

    do_req(1'b1, 3'b000, 32'h202, 32'h00000055, lat, dre, dwe);
    chk("sb202_lat", lat, 4);
    chk("sb202_re_cnt", dre, 1);
    chk("sb202_we_cnt", dwe, 1);
    chk("sb202_mem", mem[8'h80], 32'h11553344);
    do_req(1'b1, 3'b001, 32'h200, 32'hFFFFABCD, lat, dre, dwe);
    chk("sh200_lat", lat, 4);
    chk("sh200_mem", mem[8'h80], 32'h1155ABCD);
    do_req(1'b0, 3'b010, 32'h200, 32'h0, lat, dre, dwe);
    chk("lw200_rdata", bus.rsp_rdata, 32'h1155ABCD);

    do_req(1'b0, 3'b010, 32'h102, 32'h0, lat, dre, dwe);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lw102_lat", lat, 1);
    chk("lw102_fault", {31'h0, bus.rsp_fault}, 32'h1);
    chk("lw102_rdata", bus.rsp_rdata, 32'h0);
    chk("lw102_re_cnt", dre, 0);
`else
    chk("lw102_lat", lat, 3);
    chk("lw102_fault", {31'h0, bus.rsp_fault}, 32'h0);
    chk("lw102_rdata", bus.rsp_rdata, 32'h8899AABB);
    chk("lw102_re_cnt", dre, 1);
`endif

    do_req(1'b0, 3'b011, 32'h100, 32'h0, lat, dre, dwe);
    chk("ld011_lat", lat, 1);
    chk("ld011_fault", {31'h0, bus.rsp_fault}, 32'h1);
    chk("ld011_rdata", bus.rsp_rdata, 32'h0);
    chk("ld011_re_cnt", dre, 0);
    do_req(1'b1, 3'b100, 32'h100, 32'h12345678, lat, dre, dwe);
    chk("st100_fault", {31'h0, bus.rsp_fault}, 32'h1);
    chk("st100_we_cnt", dwe, 0);
    chk("st100_mem", mem[8'h40], 32'h8899AABB);

    // Reset while the SW write is on the bus.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h308; bus.req_wdata = 32'h12345678;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("rstwr_we_before", {31'h0, bus.mem_we}, 32'h1);
    v0 = n_rv; w0 = n_we;
    #1 rst = 1'b1;
    #1;
    chk("rstwr_we_after", {31'h0, bus.mem_we}, 32'h0);
    chk("rstwr_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("rstwr_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    @(negedge clk) rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rstwr_no_rsp", n_rv - v0, 0);
    chk("rstwr_no_write", n_we - w0, 0);

    // Two SW requests with req_valid held high.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h300; bus.req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    chk("b2b_e0_ready", {31'h0, bus.req_ready}, 32'h0);
    chk("b2b_e0_wdata", bus.mem_wdata, 32'hCAFEF00D);
    bus.req_addr = 32'h304; bus.req_wdata = 32'h0BADBEEF;
    @(posedge clk); #1;
    chk("b2b_e1_ready", {31'h0, bus.req_ready}, 32'h0);
    @(posedge clk); #1;
    chk("b2b_e2_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("b2b_e2_rsp", {31'h0, bus.rsp_valid}, 32'h1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("b2b_e3_ready", {31'h0, bus.req_ready}, 32'h0);
    chk("b2b_e3_we", {31'h0, bus.mem_we}, 32'h1);
    chk("b2b_e3_addr", bus.mem_addr, 32'h304);
    chk("b2b_e3_wdata", bus.mem_wdata, 32'h0BADBEEF);
    lat = 0;
    while (!bus.rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("b2b_second_lat", lat, 2);

    do_req(1'b0, 3'b010, 32'h300, 32'h0, lat, dre, dwe);
    chk("lw300_rdata", bus.rsp_rdata, 32'hCAFEF00D);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_rdata", bus.rsp_rdata, 32'hCAFEF00D);
    chk("hold_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("mem304", mem[8'hC1], 32'h0BADBEEF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
